// File: rtl/ft_bus_sequencer_if.sv
// ---------------------------------------------------------------------------
// ft_bus_sequencer_if : FT245-style FIFO pins plus tx/rx byte handshakes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ft_bus_sequencer_if;
  logic       FT_RXFn;
  logic       FT_TXEn;
  logic       FT_RDn;
  logic       FT_WR;
  logic [7:0] FT_DATA_In;
  logic [7:0] FT_DATA_Out;
  logic       FT_DATA_OE;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;

  modport master (
    input  FT_RXFn, FT_TXEn, FT_DATA_In, tx_data, tx_valid, rx_ready,
    output FT_RDn, FT_WR, FT_DATA_Out, FT_DATA_OE, tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    output FT_RXFn, FT_TXEn, FT_DATA_In, tx_data, tx_valid, rx_ready,
    input  FT_RDn, FT_WR, FT_DATA_Out, FT_DATA_OE, tx_ready, rx_data, rx_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/ft_bus_sequencer.sv
// ---------------------------------------------------------------------------
// ft_bus_sequencer : half-duplex FT245/FT232H FIFO bus read/write sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ft_bus_sequencer #(
  parameter int RD_STROBE_START = 1,
  parameter int RD_SAMPLE       = 4,
  parameter int RD_STROBE_STOP  = 5,
  parameter int RD_END          = 6,
  parameter int WR_OE_START     = 2,
  parameter int WR_STROBE_START = 5,
  parameter int WR_STROBE_STOP  = 15,
  parameter int WR_OE_STOP      = 22,
  parameter int WR_END          = 25,
  parameter int GUARD           = 3,
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst,
  ft_bus_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] RD_STROBE_START_C = CNT_W'(RD_STROBE_START);
  localparam logic [CNT_W-1:0] RD_SAMPLE_C       = CNT_W'(RD_SAMPLE);
  localparam logic [CNT_W-1:0] RD_STROBE_STOP_C  = CNT_W'(RD_STROBE_STOP);
  localparam logic [CNT_W-1:0] RD_END_C          = CNT_W'(RD_END);
  localparam logic [CNT_W-1:0] WR_OE_START_C     = CNT_W'(WR_OE_START);
  localparam logic [CNT_W-1:0] WR_STROBE_START_C = CNT_W'(WR_STROBE_START);
  localparam logic [CNT_W-1:0] WR_STROBE_STOP_C  = CNT_W'(WR_STROBE_STOP);
  localparam logic [CNT_W-1:0] WR_OE_STOP_C      = CNT_W'(WR_OE_STOP);
  localparam logic [CNT_W-1:0] WR_END_C          = CNT_W'(WR_END);
  localparam logic [CNT_W-1:0] GUARD_LAST_C      = CNT_W'(GUARD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_WR    = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic       rxf_meta, rxf_s, txe_meta, txe_s;
  logic       hold_full;
  logic [7:0] hold_data;
  logic       last_rd;
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic       rd_n_q, wr_q, oe_q;
  logic [7:0] dout_q;

  logic rd_ok, wr_ok, rd_done, wr_done;

  assign rd_ok   = rxf_s & ~rx_valid_q;
  assign wr_ok   = txe_s & hold_full;
  assign rd_done = (state == S_RD) && (cnt == RD_END_C);
  assign wr_done = (state == S_WR) && (cnt == WR_END_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Last-served direction loses the tie so both paths get alternate turns.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (rd_ok && wr_ok) state_next = last_rd ? S_WR : S_RD;
        else if (rd_ok)     state_next = S_RD;
        else if (wr_ok)     state_next = S_WR;
      end
      S_RD:    if (rd_done) state_next = S_GUARD;
      S_WR:    if (wr_done) state_next = S_GUARD;
      S_GUARD: if (cnt == GUARD_LAST_C) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    cnt_next = (state_next != state) ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxf_meta <= 1'b0;
      rxf_s    <= 1'b0;
      txe_meta <= 1'b0;
      txe_s    <= 1'b0;
    end else begin
      rxf_meta <= ~bus.FT_RXFn;
      rxf_s    <= rxf_meta;
      txe_meta <= ~bus.FT_TXEn;
      txe_s    <= txe_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full  <= 1'b0;
      hold_data  <= '0;
      last_rd    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      if (wr_done)                            hold_full <= 1'b0;
      else if (bus.tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= bus.tx_data;
      end
      if ((state == S_RD) && (cnt == RD_SAMPLE_C)) rx_data_q <= bus.FT_DATA_In;
      if (rd_done)                            rx_valid_q <= 1'b1;
      else if (rx_valid_q && bus.rx_ready)    rx_valid_q <= 1'b0;
      if (rd_done)      last_rd <= 1'b1;
      else if (wr_done) last_rd <= 1'b0;
    end
  end

  // Pin registers are computed from the next state/count so they line up with cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_n_q <= 1'b1;
      wr_q   <= 1'b0;
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      rd_n_q <= !((state_next == S_RD) && (cnt_next >= RD_STROBE_START_C)
                  && (cnt_next < RD_STROBE_STOP_C));
      wr_q   <= (state_next == S_WR) && (cnt_next >= WR_STROBE_START_C)
                  && (cnt_next < WR_STROBE_STOP_C);
      oe_q   <= (state_next == S_WR) && (cnt_next >= WR_OE_START_C)
                  && (cnt_next < WR_OE_STOP_C);
      dout_q <= (state_next == S_WR) ? hold_data : 8'h00;
    end
  end

  assign bus.FT_RDn      = rd_n_q;
  assign bus.FT_WR       = wr_q;
  assign bus.FT_DATA_OE  = oe_q;
  assign bus.FT_DATA_Out = dout_q;
  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.busy        = (state != S_IDLE);

endmodule

`default_nettype wire
